// File: rtl/vga_fb_writer.sv
// Framebuffer write front end: command FIFO plus single-write/fill sequencer.
// Optional VGA_FB_WRITER_VBLANK_GATE_EN restricts RAM writes to vertical blanking.
module vga_fb_writer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef VGA_FB_WRITER_VBLANK_GATE_EN
    input  logic                  vblank,
`endif
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] video_ram_input_addr,
    output logic [DATA_WIDTH-1:0] video_ram_input_data,
    output logic                  video_ram_we
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = ADDR_WIDTH + 1;

    typedef struct packed {
        logic                  op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [CW-1:0]         count;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    cmd_t          head;

    state_t        state, state_n;
    logic          we_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [CW-1:0] rem, rem_n;
    logic          go, take;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push  = cmd_valid && !full;
    assign head  = mem[rd_ptr[PW-1:0]];

    assign cmd_ready = !full;
    assign busy      = !empty || (state != IDLE);

`ifdef VGA_FB_WRITER_VBLANK_GATE_EN
    assign go = vblank;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= '{op: cmd_op, addr: cmd_addr,
                                     data: cmd_data, count: cmd_count};
        end
    end

    always_comb begin
        state_n = state;
        we_n    = 1'b0;
        addr_n  = video_ram_input_addr;
        data_n  = video_ram_input_data;
        rem_n   = rem;
        pop     = 1'b0;
        take    = 1'b0;
        // With go low everything holds and we stays low.
        if (go) begin
            unique case (state)
                IDLE:  take = 1'b1;
                WRITE: take = 1'b1;
                FILL: begin
                    if (rem != '0) begin
                        addr_n = ADDR_WIDTH'(video_ram_input_addr + 1'b1);
                        we_n   = 1'b1;
                        rem_n  = rem - 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
                default: take = 1'b1;
            endcase
        end
        if (take) begin
            state_n = IDLE;
            if (!empty) begin
                pop = 1'b1;
                if (!head.op) begin
                    addr_n  = head.addr;
                    data_n  = head.data;
                    we_n    = 1'b1;
                    state_n = WRITE;
                end else if (head.count != '0) begin
                    addr_n  = head.addr;
                    data_n  = head.data;
                    we_n    = 1'b1;
                    rem_n   = head.count - 1'b1;
                    state_n = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            state                <= IDLE;
            video_ram_we         <= 1'b0;
            video_ram_input_addr <= '0;
            video_ram_input_data <= '0;
            rem                  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            state                <= state_n;
            video_ram_we         <= we_n;
            video_ram_input_addr <= addr_n;
            video_ram_input_data <= data_n;
            rem                  <= rem_n;
        end
    end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: writes, fills, backpressure, reset abort.
// Also exercises the vblank gate when VGA_FB_WRITER_VBLANK_GATE_EN is defined.
module tb_vga_fb_writer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [12:0] cmd_count;
    logic        busy;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_we;
`ifdef VGA_FB_WRITER_VBLANK_GATE_EN
    logic        vblank;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [11:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];

    vga_fb_writer #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_FB_WRITER_VBLANK_GATE_EN
        .vblank(vblank),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .cmd_count(cmd_count),
        .busy(busy),
        .video_ram_input_addr(ram_addr),
        .video_ram_input_data(ram_data),
        .video_ram_we(ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log each we cycle at the edge that closes it.
    always @(posedge clk) begin
        if (ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_data);
            wc.push_back(cyc);
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push(input logic op, input logic [11:0] a,
                        input logic [15:0] d, input logic [12:0] c);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_count = c;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        cmd_count = '0;
`ifdef VGA_FB_WRITER_VBLANK_GATE_EN
        vblank = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_addr", {20'd0, ram_addr}, 32'd0);
        chk("rst_data", {16'd0, ram_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // single write
        clr();
        push(1'b0, 12'h010, 16'hBEEF, 13'd0);
        chk("sw_we_lat", {31'd0, ram_we}, 32'd0);
        chk("sw_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("sw_we", {31'd0, ram_we}, 32'd1);
        chk("sw_addr", {20'd0, ram_addr}, 32'h010);
        chk("sw_data", {16'd0, ram_data}, 32'hBEEF);
        @(negedge clk);
        chk("sw_we_off", {31'd0, ram_we}, 32'd0);
        chk("sw_busy_off", {31'd0, busy}, 32'd0);
        chk("sw_addr_hold", {20'd0, ram_addr}, 32'h010);
        chk("sw_count", wa.size(), 32'd1);

        // back-to-back writes
        clr();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
            push(1'b0, 12'(i), 16'(16'hA000 + i), 13'd0);
        end
        wait_idle("b2b_idle");
        chk("b2b_count", wa.size(), 32'd4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk("b2b_addr", {20'd0, wa[i]}, 32'(i));
            chk("b2b_data", {16'd0, wd[i]}, 32'(16'hA000 + i));
            chk("b2b_cyc", wc[i] - wc[0], 32'(i));
        end

        // fill with wrap
        clr();
        push(1'b1, 12'hFFE, 16'h0700, 13'd4);
        wait_idle("wrap_idle");
        chk("wrap_count", wa.size(), 32'd4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk("wrap_addr", {20'd0, wa[i]}, 32'(12'(12'hFFE + i)));
            chk("wrap_data", {16'd0, wd[i]}, 32'h0700);
            chk("wrap_cyc", wc[i] - wc[0], 32'(i));
        end

        // backpressure behind a long fill
        clr();
        push(1'b1, 12'h100, 16'h5A5A, 13'd100);
        for (int j = 0; j < 4; j++)
            push(1'b0, 12'(12'h200 + j), 16'(16'h1000 + j), 13'd0);
        chk("bp_full", {31'd0, cmd_ready}, 32'd0);
        push(1'b0, 12'h204, 16'h1004, 13'd0);
        wait_idle("bp_idle");
        chk("bp_count", wa.size(), 32'd105);
        for (int i = 0; i < 100 && i < wa.size(); i++)
            chk("bp_fill_addr", {20'd0, wa[i]}, 32'(12'h100 + i));
        for (int j = 0; j < 5 && 100 + j < wa.size(); j++) begin
            chk("bp_wr_addr", {20'd0, wa[100+j]}, 32'(12'h200 + j));
            chk("bp_wr_data", {16'd0, wd[100+j]}, 32'(16'h1000 + j));
        end

        // zero-count fill
        clr();
        push(1'b1, 12'h123, 16'h5555, 13'd0);
        repeat (4) @(negedge clk);
        chk("zero_count", wa.size(), 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);

        // reset aborts a fill and flushes the queued write
        clr();
        push(1'b1, 12'h300, 16'h0300, 13'd50);
        push(1'b0, 12'h7AA, 16'h1234, 13'd0);
        n = 0;
        while (wa.size() < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", wa.size(), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", {31'd0, ram_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_addr", {20'd0, ram_addr}, 32'd0);
        chk("abort_data", {16'd0, ram_data}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_words", wa.size(), 32'd11);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_flush", wa.size(), 32'd11);
        chk("abort_idle", {31'd0, busy}, 32'd0);

`ifdef VGA_FB_WRITER_VBLANK_GATE_EN
        clr();
        push(1'b1, 12'h400, 16'h0400, 13'd8);
        n = 0;
        while (wa.size() < 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vblank = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("vb_we_low", {31'd0, ram_we}, 32'd0);
        end
        chk("vb_held", wa.size(), 32'd4);
        vblank = 1'b1;
        wait_idle("vb_idle");
        chk("vb_count", wa.size(), 32'd8);
        for (int i = 0; i < 8 && i < wa.size(); i++)
            chk("vb_addr", {20'd0, wa[i]}, 32'(12'h400 + i));
        if (wa.size() == 8) begin
            chk("vb_gap", {31'd0, (wc[4] - wc[3]) > 20}, 32'd1);
            for (int i = 5; i < 8; i++)
                chk("vb_cyc", wc[i] - wc[4], 32'(i - 4));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
